// File: rtl/imem_loader.sv
// Framed byte-stream loader into imem (H0 H1, 4*N MSB-first data bytes, XOR checksum); CPU held in reset until verified.
// All outputs registered, 5 cycles per word minimum; in_ready low in IDLE/WRITE/DONE, in_valid stalls hold all state.
module imem_loader #(
  parameter logic [11:0] BASE_ADDR = 12'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] imem_address,
  output logic [31:0] imem_data,
  output logic        imem_wren,
  output logic        cpu_reset_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t      state;
  logic [7:0]  csum;
  logic [3:0]  n_hi;
  logic [11:0] words_left;
  logic [1:0]  byte_cnt;
  logic        xfer;
  logic        csum_bad;
  logic [11:0] n_words;

  assign xfer     = in_valid && in_ready;
  assign csum_bad = (in_data != csum);
  assign n_words  = {n_hi, in_data};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      in_ready       <= 1'b0;
      imem_wren      <= 1'b0;
      imem_address   <= BASE_ADDR;
      imem_data      <= 32'd0;
      cpu_reset_hold <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
      csum           <= 8'd0;
      n_hi           <= 4'd0;
      words_left     <= 12'd0;
      byte_cnt       <= 2'd0;
    end else begin
      imem_wren <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_HDR_HI;
            in_ready       <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            cpu_reset_hold <= 1'b1;
            csum           <= 8'd0;
            imem_address   <= BASE_ADDR;
          end
        end
        S_HDR_HI: begin
          if (xfer) begin
            n_hi  <= in_data[3:0];
            csum  <= csum ^ in_data;
            state <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (xfer) begin
            words_left <= n_words;
            csum       <= csum ^ in_data;
            byte_cnt   <= 2'd0;
            state      <= (n_words != 12'd0) ? S_DATA : S_CHECK;
          end
        end
        S_DATA: begin
          if (xfer) begin
            imem_data <= {imem_data[23:0], in_data};
            csum      <= csum ^ in_data;
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state     <= S_WRITE;
              in_ready  <= 1'b0;
              imem_wren <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          // address wraps silently at 4095
          imem_address <= imem_address + 12'd1;
          words_left   <= words_left - 12'd1;
          in_ready     <= 1'b1;
          state        <= (words_left == 12'd1) ? S_CHECK : S_DATA;
        end
        S_CHECK: begin
          if (xfer) begin
            error          <= csum_bad;
            cpu_reset_hold <= csum_bad;
            done           <= 1'b1;
            in_ready       <= 1'b0;
            state          <= S_DONE;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; two instances (base 0 and base 0xFFF) share one stimulus stream.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;

  logic        in_ready0, wren0, hold0, done0, error0;
  logic [11:0] addr0;
  logic [31:0] data0;
  logic        in_ready1, wren1, hold1, done1, error1;
  logic [11:0] addr1;
  logic [31:0] data1;

  imem_loader #(.BASE_ADDR(12'd0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .imem_address(addr0), .imem_data(data0), .imem_wren(wren0),
    .cpu_reset_hold(hold0), .done(done0), .error(error0)
  );

  imem_loader #(.BASE_ADDR(12'hFFF)) dut1 (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .imem_address(addr1), .imem_data(data1), .imem_wren(wren1),
    .cpu_reset_hold(hold1), .done(done1), .error(error1)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [31:0] wq[$];
  logic [11:0] a0q[$], a1q[$];
  logic [31:0] d0q[$], d1q[$];
  int          dbl0 = 0, dbl1 = 0;
  logic        pw0 = 1'b0, pw1 = 1'b0;

  // write log: one entry per wren cycle, plus count of wren held two cycles in a row
  always @(negedge clock) begin
    if (wren0) begin a0q.push_back(addr0); d0q.push_back(data0); end
    if (wren1) begin a1q.push_back(addr1); d1q.push_back(data1); end
    if (wren0 && pw0) dbl0++;
    if (wren1 && pw1) dbl1++;
    pw0 = wren0;
    pw1 = wren1;
  end

  function automatic logic [11:0] exp_addr(input logic [11:0] base, input int i);
    return 12'((int'(base) + i) % 4096);
  endfunction

  task automatic pulse_start(output int e0);
    start = 1'b1;
    @(posedge clock); #1;
    e0 = cyc;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stalls, output bit ok);
    if (stalls && $urandom_range(0, 1) == 0)
      repeat ($urandom_range(1, 3)) begin @(posedge clock); #1; end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      ok = in_ready0;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  // Frame built from wq: header, MSB-first words, XOR checksum (optionally corrupted).
  task automatic run_frame(input int n, input logic [3:0] hi_nib, input bit bad, input bit stalls,
                           input bit mid_start, output int e0, output int ec, output int hs_fail);
    logic [7:0]  bq[$];
    logic [11:0] nn;
    logic [7:0]  c;
    bit          ok;
    nn = 12'(n);
    bq.push_back({hi_nib, nn[11:8]});
    bq.push_back(nn[7:0]);
    foreach (wq[k]) begin
      bq.push_back(wq[k][31:24]); bq.push_back(wq[k][23:16]);
      bq.push_back(wq[k][15:8]);  bq.push_back(wq[k][7:0]);
    end
    c = 8'd0;
    foreach (bq[k]) c = c ^ bq[k];
    if (bad) c = c ^ 8'h01;
    bq.push_back(c);
    a0q.delete(); a1q.delete(); d0q.delete(); d1q.delete();
    dbl0 = 0; dbl1 = 0;
    hs_fail = 0;
    ec = 0;
    pulse_start(e0);
    foreach (bq[k]) begin
      send_byte(bq[k], stalls, ok);
      if (!ok) hs_fail++;
      if (mid_start && k == 2) begin
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
      end
      ec = cyc;
    end
  endtask

  task automatic test_reset;
    tests++;
    if ({in_ready0, wren0, addr0, data0, hold0, done0, error0, in_ready1, wren1, addr1, data1, hold1, done1, error1}
        !== {1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: got rdy=%b wren=%b addr=%h data=%h hold=%b done=%b err=%b addr1=%h, required 0 0 000 00000000 1 0 0 fff",
               in_ready0, wren0, addr0, data0, hold0, done0, error0, addr1);
    end
  endtask

  task automatic test_two_word;
    int e0, ec, hf;
    wq = '{32'h20010005, 32'h20020007};
    run_frame(2, 4'h0, 1'b0, 1'b0, 1'b0, e0, ec, hf);
    @(negedge clock);
    tests++;
    if (hf != 0) begin fails++; $display("FAIL two_word_handshake: %0d bytes not accepted, required 0", hf); end
    tests++;
    if (ec - e0 != 13) begin fails++; $display("FAIL two_word_latency: got %0d cycles, required 13", ec - e0); end
    tests++;
    if (a0q.size() != 2 || a1q.size() != 2 || dbl0 != 0 || dbl1 != 0) begin
      fails++;
      $display("FAIL two_word_wren: got %0d/%0d writes dbl %0d/%0d, required 2/2 dbl 0/0", a0q.size(), a1q.size(), dbl0, dbl1);
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (a0q[i] !== exp_addr(12'h000, i) || d0q[i] !== wq[i] || a1q[i] !== exp_addr(12'hFFF, i) || d1q[i] !== wq[i]) begin
          fails++;
          $display("FAIL two_word_write%0d: got %h@%h / %h@%h, required %h@%h / %h@%h", i, d0q[i], a0q[i], d1q[i], a1q[i],
                   wq[i], exp_addr(12'h000, i), wq[i], exp_addr(12'hFFF, i));
        end
      end
    end
    tests++;
    if ({done0, error0, hold0, done1, error1, hold1} !== 6'b100_100) begin
      fails++;
      $display("FAIL two_word_status: got done/err/hold %b%b%b %b%b%b, required 100 100", done0, error0, hold0, done1, error1, hold1);
    end
  endtask

  task automatic test_bad_checksum;
    int e0, ec, hf;
    wq = '{32'h20010005, 32'h20020007};
    run_frame(2, 4'h0, 1'b1, 1'b0, 1'b0, e0, ec, hf);
    @(negedge clock);
    tests++;
    if (hf != 0 || a0q.size() != 2 || d0q[0] !== 32'h20010005 || d0q[1] !== 32'h20020007) begin
      fails++;
      $display("FAIL bad_csum_writes: got %0d writes (hs fail %0d), required 2 words written", a0q.size(), hf);
    end
    tests++;
    if ({done0, error0, hold0, done1, error1, hold1} !== 6'b111_111) begin
      fails++;
      $display("FAIL bad_csum_status: got done/err/hold %b%b%b %b%b%b, required 111 111", done0, error0, hold0, done1, error1, hold1);
    end
    wq = '{$urandom, $urandom, $urandom};
    run_frame(3, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0, e0, ec, hf);
    @(negedge clock);
    tests++;
    if ({done0, error0, hold0, done1, error1, hold1} !== 6'b100_100 || a0q.size() != 3) begin
      fails++;
      $display("FAIL bad_csum_recover: got done/err/hold %b%b%b %b%b%b writes %0d, required 100 100 writes 3",
               done0, error0, hold0, done1, error1, hold1, a0q.size());
    end
  endtask

  task automatic test_empty;
    int e0, ec, hf;
    wq.delete();
    run_frame(0, 4'h0, 1'b0, 1'b0, 1'b0, e0, ec, hf);
    @(negedge clock);
    tests++;
    if (hf != 0 || ec - e0 != 3 || a0q.size() != 0 || a1q.size() != 0) begin
      fails++;
      $display("FAIL empty_frame: got %0d cycles, %0d writes, hs fail %0d, required 3 cycles, 0 writes, 0", ec - e0, a0q.size(), hf);
    end
    tests++;
    if ({done0, error0, hold0} !== 3'b100) begin
      fails++;
      $display("FAIL empty_status: got done/err/hold %b%b%b, required 100", done0, error0, hold0);
    end
  endtask

  task automatic test_wrap_stalls;
    int e0, ec, hf;
    wq = '{$urandom, $urandom};
    run_frame(2, 4'($urandom_range(0, 15)), 1'b0, 1'b1, 1'b0, e0, ec, hf);
    @(negedge clock);
    tests++;
    if (hf != 0 || a1q.size() != 2 || dbl1 != 0) begin
      fails++;
      $display("FAIL wrap_count: got %0d writes dbl %0d hs fail %0d, required 2 writes dbl 0", a1q.size(), dbl1, hf);
    end else begin
      tests++;
      if (a1q[0] !== 12'hFFF || a1q[1] !== 12'h000 || d1q[0] !== wq[0] || d1q[1] !== wq[1]) begin
        fails++;
        $display("FAIL wrap_writes: got %h@%h %h@%h, required %h@fff %h@000", d1q[0], a1q[0], d1q[1], a1q[1], wq[0], wq[1]);
      end
    end
    tests++;
    if ({done1, error1, hold1} !== 3'b100) begin
      fails++;
      $display("FAIL wrap_status: got done/err/hold %b%b%b, required 100", done1, error1, hold1);
    end
  endtask

  task automatic test_reset_mid_word;
    int  e0, ec, hf;
    bit  ok;
    logic [7:0] partial[4] = '{8'h00, 8'h02, 8'h20, 8'h01};
    a0q.delete(); a1q.delete();
    pulse_start(e0);
    foreach (partial[k]) send_byte(partial[k], 1'b0, ok);
    #2 reset = 1'b0;
    #1;
    test_reset;
    tests++;
    if (a0q.size() != 0) begin fails++; $display("FAIL reset_mid_word_nowrite: got %0d writes, required 0", a0q.size()); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    wq = '{32'h20010005, 32'h20020007};
    run_frame(2, 4'h0, 1'b0, 1'b0, 1'b0, e0, ec, hf);
    @(negedge clock);
    tests++;
    if (hf != 0 || ec - e0 != 13 || a0q.size() != 2 || d0q[0] !== 32'h20010005 || d0q[1] !== 32'h20020007
        || a0q[0] !== 12'h000 || a0q[1] !== 12'h001) begin
      fails++;
      $display("FAIL reset_reload: got %0d writes in %0d cycles, required 20010005@000 20020007@001 in 13", a0q.size(), ec - e0);
    end
    tests++;
    if ({done0, error0, hold0} !== 3'b100) begin
      fails++;
      $display("FAIL reset_reload_status: got done/err/hold %b%b%b, required 100", done0, error0, hold0);
    end
  endtask

  task automatic test_start_mid_frame;
    int e0, ec, hf;
    wq = '{$urandom, $urandom};
    run_frame(2, 4'h0, 1'b0, 1'b0, 1'b1, e0, ec, hf);
    @(negedge clock);
    tests++;
    if (hf != 0 || a0q.size() != 2 || d0q[0] !== wq[0] || d0q[1] !== wq[1] || {done0, error0, hold0} !== 3'b100) begin
      fails++;
      $display("FAIL start_mid_frame: got %0d writes done/err/hold %b%b%b, required 2 writes 100", a0q.size(), done0, error0, hold0);
    end
  endtask

  task automatic test_random_loads;
    int e0, ec, hf, n;
    bit bad;
    for (int f = 0; f < 5; f++) begin
      n   = $urandom_range(1, 5);
      bad = 1'($urandom_range(0, 1));
      wq.delete();
      repeat (n) wq.push_back($urandom);
      run_frame(n, 4'($urandom_range(0, 15)), bad, 1'b1, 1'b0, e0, ec, hf);
      @(negedge clock);
      tests++;
      if (hf != 0 || a0q.size() != n || a1q.size() != n || dbl0 != 0) begin
        fails++;
        $display("FAIL random_count%0d: got %0d/%0d writes dbl %0d hs %0d, required %0d", f, a0q.size(), a1q.size(), dbl0, hf, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          tests++;
          if (a0q[i] !== exp_addr(12'h000, i) || d0q[i] !== wq[i] || a1q[i] !== exp_addr(12'hFFF, i) || d1q[i] !== wq[i]) begin
            fails++;
            $display("FAIL random_write%0d_%0d: got %h@%h / %h@%h, required %h@%h / %h@%h", f, i, d0q[i], a0q[i], d1q[i], a1q[i],
                     wq[i], exp_addr(12'h000, i), wq[i], exp_addr(12'hFFF, i));
          end
        end
      end
      tests++;
      if ({done0, error0, hold0} !== {1'b1, bad, bad}) begin
        fails++;
        $display("FAIL random_status%0d: got done/err/hold %b%b%b, required 1%b%b", f, done0, error0, hold0, bad, bad);
      end
    end
  endtask

  initial begin
    #12;
    test_reset;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    test_two_word;
    test_bad_checksum;
    test_empty;
    test_wrap_stalls;
    test_reset_mid_word;
    test_start_mid_frame;
    test_random_loads;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required completion within time limit");
    $fatal(1);
  end

endmodule
